// File: rtl/time_setter.sv
// time_setter: debounces MODE/INC and runs the hours/minutes set-mode FSM,
// producing the counter load pulse, display values and edit-field blink mask.
module time_setter #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int BLINK_CYCLES    = 12_500_000,
   parameter int TIMEOUT_CYCLES  = 500_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode_n,
   input  logic       btn_inc_n,
   input  logic [5:0] cur_hours,
   input  logic [5:0] cur_minutes,
   output logic       load,
   output logic [5:0] load_hours,
   output logic [5:0] load_minutes,
   output logic [5:0] show_hours,
   output logic [5:0] show_minutes,
   output logic       editing,
   output logic [5:0] blank_mask
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int BW = $clog2(BLINK_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {RUN, SET_HOURS, SET_MINUTES, COMMIT} state_t;
   state_t        r_state;
   logic [1:0]    w_raw, r_s1, r_s2, r_db, r_db_d;
   logic [DW-1:0] r_dcnt [2];
   logic          r_load, r_phase;
   logic [5:0]    r_edit_h, r_edit_m;
   logic [TW-1:0] r_idle;
   logic [BW-1:0] r_bcnt;
   logic          w_mode, w_inc, w_editing, w_timeout, w_bwrap, w_bclr;
   // bit 0 = MODE, bit 1 = INC; all levels are active-low
   assign w_raw = {btn_inc_n, btn_mode_n};
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_s1   <= '1;
         r_s2   <= '1;
         r_db   <= '1;
         r_db_d <= '1;
         r_dcnt <= '{default: '0};
      end else begin
         r_s1   <= w_raw;
         r_s2   <= r_s1;
         r_db_d <= r_db;
         for (int i = 0; i < 2; i++)
            if (r_s2[i] == r_db[i]) r_dcnt[i] <= '0;
            else if (r_dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               r_db[i]   <= r_s2[i];
               r_dcnt[i] <= '0;
            end else r_dcnt[i] <= r_dcnt[i] + 1'b1;
      end
   assign w_mode    = r_db_d[0] & ~r_db[0];
   assign w_inc     = r_db_d[1] & ~r_db[1];
   assign w_editing = (r_state == SET_HOURS) || (r_state == SET_MINUTES);
   assign w_timeout = r_idle == TW'(TIMEOUT_CYCLES - 1);
   assign w_bwrap   = r_bcnt == BW'(BLINK_CYCLES - 1);
   // any press while editing either enters a new edit state or changes the value
   assign w_bclr    = !w_editing || w_mode || w_inc;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_state  <= RUN;
         r_load   <= 1'b0;
         r_edit_h <= '0;
         r_edit_m <= '0;
         r_idle   <= '0;
         r_bcnt   <= '0;
         r_phase  <= 1'b0;
      end else begin
         r_load  <= 1'b0;
         r_idle  <= (w_editing && !w_mode && !w_inc && !w_timeout) ? r_idle + 1'b1 : '0;
         r_bcnt  <= (w_bclr || w_bwrap) ? '0 : r_bcnt + 1'b1;
         r_phase <= !w_bclr && (r_phase ^ w_bwrap);
         case (r_state)
            RUN:
               if (w_mode) begin
                  r_state  <= SET_HOURS;
                  r_edit_h <= cur_hours;
                  r_edit_m <= cur_minutes;
               end
            SET_HOURS:
               if (w_mode) r_state <= SET_MINUTES;
               else if (w_inc) r_edit_h <= (r_edit_h == 6'd23) ? 6'd0 : r_edit_h + 6'd1;
               else if (w_timeout) r_state <= RUN;
            SET_MINUTES:
               if (w_mode) begin
                  r_state <= COMMIT;
                  r_load  <= 1'b1;
               end else if (w_inc) r_edit_m <= (r_edit_m == 6'd59) ? 6'd0 : r_edit_m + 6'd1;
               else if (w_timeout) r_state <= RUN;
            default: r_state <= RUN;
         endcase
      end
   assign load         = r_load;
   assign load_hours   = r_edit_h;
   assign load_minutes = r_edit_m;
   assign editing      = w_editing;
   assign show_hours   = w_editing ? r_edit_h : cur_hours;
   assign show_minutes = w_editing ? r_edit_m : cur_minutes;
   assign blank_mask   = (r_state == SET_HOURS)   ? {r_phase, r_phase, 4'b0} :
                         (r_state == SET_MINUTES) ? {2'b0, r_phase, r_phase, 2'b0} : 6'b0;
endmodule

// File: tb/tb_time_setter.sv
// tb_time_setter: directed vector table plus timed sequences for latency,
// blink, load pulse, glitch rejection, timeout and reset corner cases.
module tb_time_setter;
   typedef struct {int act, reps, ch, cm, ed, sh, sm, ld, lh, lm;} vec_t;
   logic       clk = 0, rst = 0, mode_n = 1, inc_n = 1;
   logic [5:0] cur_h = 6'd9, cur_m = 6'd41;
   logic       load, editing;
   logic [5:0] load_hours, load_minutes, show_hours, show_minutes, blank_mask;
   int         checks = 0, fails = 0, load_cnt = 0, bad;
   logic [5:0] last_lh = 0, last_lm = 0;
   vec_t       tv [22];

   always #5 clk = ~clk;

   time_setter #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst(rst), .btn_mode_n(mode_n), .btn_inc_n(inc_n),
      .cur_hours(cur_h), .cur_minutes(cur_m), .load(load),
      .load_hours(load_hours), .load_minutes(load_minutes),
      .show_hours(show_hours), .show_minutes(show_minutes),
      .editing(editing), .blank_mask(blank_mask));

   always @(posedge clk)
      if (load) begin
         load_cnt <= load_cnt + 1;
         last_lh  <= load_hours;
         last_lm  <= load_minutes;
      end

   task automatic chk(input string n, input int a, input int e);
      checks++;
      if (a != e) begin
         fails++;
         $display("FAIL %s actual=%0d expected=%0d", n, a, e);
      end
   endtask

   task automatic press(input int b);
      if (b == 0) mode_n = 0; else inc_n = 0;
      repeat (10) @(negedge clk);
      mode_n = 1;
      inc_n  = 1;
      repeat (12) @(negedge clk);
   endtask

   // drive low at a negedge and stop one cycle before the press takes effect
   task automatic tpress(input int b);
      if (b == 0) mode_n = 0; else inc_n = 0;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      tv = '{
         '{0, 2, 12, 34, 0, 12, 34, 0, 0, 0},
         '{1, 1, 12, 34, 1, 12, 34, 0, 0, 0},
         '{2, 11, 12, 34, 1, 23, 34, 0, 0, 0},
         '{2, 1, 12, 34, 1, 0, 34, 0, 0, 0},
         '{0, 5, 5, 6, 1, 0, 34, 0, 0, 0},
         '{1, 1, 5, 6, 1, 0, 34, 0, 0, 0},
         '{2, 24, 5, 6, 1, 0, 58, 0, 0, 0},
         '{2, 1, 5, 6, 1, 0, 59, 0, 0, 0},
         '{2, 1, 5, 6, 1, 0, 0, 0, 0, 0},
         '{2, 2, 5, 6, 1, 0, 2, 0, 0, 0},
         '{1, 1, 5, 6, 0, 5, 6, 1, 0, 2},
         '{2, 1, 5, 6, 0, 5, 6, 1, 0, 2},
         '{0, 2, 23, 59, 0, 23, 59, 1, 0, 2},
         '{1, 1, 23, 59, 1, 23, 59, 1, 0, 2},
         '{2, 1, 23, 59, 1, 0, 59, 1, 0, 2},
         '{1, 1, 23, 59, 1, 0, 59, 1, 0, 2},
         '{2, 1, 23, 59, 1, 0, 0, 1, 0, 2},
         '{1, 1, 23, 59, 0, 23, 59, 2, 0, 0},
         '{0, 2, 30, 61, 0, 30, 61, 2, 0, 0},
         '{1, 1, 30, 61, 1, 30, 61, 2, 0, 0},
         '{2, 1, 30, 61, 1, 31, 61, 2, 0, 0},
         '{0, 80, 30, 61, 0, 30, 61, 2, 0, 0}};
      repeat (3) @(negedge clk);
      rst = 1;
      @(negedge clk);
      chk("rst_load", load, 0);
      chk("rst_editing", editing, 0);
      chk("rst_blank", blank_mask, 0);
      chk("rst_load_h", load_hours, 0);
      chk("rst_load_m", load_minutes, 0);
      chk("rst_show_h", show_hours, 9);
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (load || editing || blank_mask != 0 || show_hours != cur_h) bad++;
      end
      chk("idle100_bad_cycles", bad, 0);
      for (int i = 0; i < 22; i++) begin
         cur_h = 6'(tv[i].ch);
         cur_m = 6'(tv[i].cm);
         if (tv[i].act == 0) repeat (tv[i].reps) @(negedge clk);
         else for (int r = 0; r < tv[i].reps; r++) press(tv[i].act - 1);
         chk($sformatf("v%0d_editing", i), editing, tv[i].ed);
         chk($sformatf("v%0d_show_h", i), show_hours, tv[i].sh);
         chk($sformatf("v%0d_show_m", i), show_minutes, tv[i].sm);
         chk($sformatf("v%0d_loads", i), load_cnt, tv[i].ld);
         chk($sformatf("v%0d_last_lh", i), last_lh, tv[i].lh);
         chk($sformatf("v%0d_last_lm", i), last_lm, tv[i].lm);
      end
      // press latency, blink period, INC forcing phase visible, held INC
      cur_h = 6'd12;
      cur_m = 6'd34;
      tpress(0);
      chk("lat_pre_editing", editing, 0);
      @(negedge clk);
      chk("lat_post_editing", editing, 1);
      chk("enter_show_h", show_hours, 12);
      chk("enter_show_m", show_minutes, 34);
      mode_n = 1;
      for (int k = 0; k < 24; k++) begin
         chk($sformatf("blink_h_%0d", k), blank_mask, ((k / 8) % 2) ? 6'b110000 : 6'b0);
         @(negedge clk);
      end
      tpress(1);
      chk("inc_pre_show_h", show_hours, 12);
      chk("inc_pre_blank", blank_mask, 6'b110000);
      @(negedge clk);
      chk("inc_post_show_h", show_hours, 13);
      chk("inc_post_blank", blank_mask, 0);
      repeat (30) @(negedge clk);
      chk("hold_inc_show_h", show_hours, 13);
      inc_n = 1;
      repeat (12) @(negedge clk);
      // into SET_MINUTES, minute blink, then exact load pulse
      tpress(0);
      chk("m_pre_editing", editing, 1);
      @(negedge clk);
      chk("m_show", {show_hours, show_minutes}, {6'd13, 6'd34});
      mode_n = 1;
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("blink_m_%0d", k), blank_mask, ((k / 8) % 2) ? 6'b001100 : 6'b0);
         @(negedge clk);
      end
      tpress(0);
      chk("commit_pre_load", load, 0);
      chk("commit_pre_editing", editing, 1);
      @(negedge clk);
      chk("commit_load", load, 1);
      chk("commit_load_h", load_hours, 13);
      chk("commit_load_m", load_minutes, 34);
      chk("commit_editing", editing, 0);
      @(negedge clk);
      chk("after_load", load, 0);
      chk("after_load_h", load_hours, 13);
      chk("after_load_m", load_minutes, 34);
      chk("after_show_h", show_hours, 12);
      mode_n = 1;
      repeat (12) @(negedge clk);
      // glitch rejection and bounce
      press(0);
      inc_n = 0;
      repeat (3) @(negedge clk);
      inc_n = 1;
      repeat (15) @(negedge clk);
      chk("glitch_show_h", show_hours, 12);
      @(negedge clk);
      inc_n = 0;
      @(negedge clk);
      inc_n = 1;
      @(negedge clk);
      inc_n = 0;
      repeat (15) @(negedge clk);
      chk("bounce_show_h", show_hours, 13);
      inc_n = 1;
      repeat (12) @(negedge clk);
      // simultaneous MODE and INC: mode wins
      mode_n = 0;
      inc_n  = 0;
      repeat (10) @(negedge clk);
      mode_n = 1;
      inc_n  = 1;
      repeat (12) @(negedge clk);
      chk("simul_editing", editing, 1);
      chk("simul_show", {show_hours, show_minutes}, {6'd13, 6'd34});
      press(1);
      chk("simul_then_inc", {show_hours, show_minutes}, {6'd13, 6'd35});
      // asynchronous reset mid-edit
      rst = 0;
      #1;
      chk("arst_editing", editing, 0);
      chk("arst_load", load, 0);
      chk("arst_load_hm", {load_hours, load_minutes}, 0);
      chk("arst_blank", blank_mask, 0);
      chk("arst_show", {show_hours, show_minutes}, {6'd12, 6'd34});
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      chk("arst_editing_after", editing, 0);
      chk("arst_load_cnt", load_cnt, 3);
      // exact timeout
      cur_h = 6'd7;
      cur_m = 6'd8;
      tpress(0);
      @(negedge clk);
      mode_n = 1;
      chk("to_enter_editing", editing, 1);
      repeat (63) @(negedge clk);
      chk("to_63_editing", editing, 1);
      @(negedge clk);
      chk("to_64_editing", editing, 0);
      chk("to_show", {show_hours, show_minutes}, {6'd7, 6'd8});
      chk("to_blank", blank_mask, 0);
      chk("to_load_cnt", load_cnt, 3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
